// File: rtl/knight_tour_monitor.sv
// knight_tour_monitor: watches the Knight's settled positions and flags
// off-board squares, non-knight moves, revisits, moves after completion,
// stray settle pulses while idle and stalls. Errors are sticky; the first
// error code wins until the next start or reset.
module knight_tour_monitor #(
  parameter int BOARD_W      = 5,
  parameter int BOARD_H      = 5,
  parameter int TIMEOUT_CLKS = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] start_x,
  input  logic [2:0] start_y,
  input  logic       pos_vld,
  input  logic [2:0] pos_x,
  input  logic [2:0] pos_y,
  output logic       busy,
  output logic [6:0] mv_cnt,
  output logic       tour_done,
  output logic       err,
  output logic [2:0] err_code
);

  localparam int NSQ = BOARD_W * BOARD_H;
  localparam int TW  = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS + 1);

  localparam logic [2:0] EC_NONE    = 3'd0;
  localparam logic [2:0] EC_OFF     = 3'd1;
  localparam logic [2:0] EC_ILLEGAL = 3'd2;
  localparam logic [2:0] EC_REVISIT = 3'd3;
  localparam logic [2:0] EC_AFTER   = 3'd4;
  localparam logic [2:0] EC_IDLE    = 3'd5;
  localparam logic [2:0] EC_TIMEOUT = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t         state, state_nxt;
  logic [NSQ-1:0] visited, visited_nxt;
  logic [2:0]     lx, ly, lx_nxt, ly_nxt;
  logic [6:0]     mv_cnt_nxt;
  logic           tour_done_nxt;
  logic           err_nxt;
  logic [2:0]     err_code_nxt;
  logic [TW-1:0]  to_cnt, to_cnt_nxt, to_cnt_inc;

  logic           start_on, pos_on;
  logic [6:0]     start_idx, pos_idx;
  logic [NSQ-1:0] start_mask, pos_mask;
  logic [2:0]     adx, ady;
  logic           knight_ok, revisit, to_hit;
  logic [6:0]     mv_inc;

  assign busy = (state == ST_TRACK);

  assign start_on  = ({1'b0, start_x} < 4'(BOARD_W)) && ({1'b0, start_y} < 4'(BOARD_H));
  assign pos_on    = ({1'b0, pos_x} < 4'(BOARD_W)) && ({1'b0, pos_y} < 4'(BOARD_H));
  assign start_idx = 7'(start_y) * 7'(BOARD_W) + 7'(start_x);
  assign pos_idx   = 7'(pos_y) * 7'(BOARD_W) + 7'(pos_x);

  // One-hot square masks; only meaningful when the square is on the board
  always_comb begin
    start_mask = '0;
    pos_mask   = '0;
    for (int unsigned i = 0; i < NSQ; i++) begin
      start_mask[i] = (start_idx == 7'(i));
      pos_mask[i]   = (pos_idx == 7'(i));
    end
  end

  // Unsigned magnitudes are equivalent to the 4-bit signed deltas' abs values
  assign adx       = (pos_x >= lx) ? (pos_x - lx) : (lx - pos_x);
  assign ady       = (pos_y >= ly) ? (pos_y - ly) : (ly - pos_y);
  assign knight_ok = ((adx == 3'd1) && (ady == 3'd2)) || ((adx == 3'd2) && (ady == 3'd1));
  assign revisit   = |(visited & pos_mask);
  assign mv_inc    = mv_cnt + 7'd1;

  assign to_cnt_inc = to_cnt + TW'(1);
  assign to_hit     = (TIMEOUT_CLKS != 0) && (to_cnt_inc == TW'(TIMEOUT_CLKS));

  // State and tracking registers; reset clears every trace of a tour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      visited   <= '0;
      lx        <= '0;
      ly        <= '0;
      mv_cnt    <= '0;
      tour_done <= 1'b0;
      err       <= 1'b0;
      err_code  <= EC_NONE;
      to_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      visited   <= visited_nxt;
      lx        <= lx_nxt;
      ly        <= ly_nxt;
      mv_cnt    <= mv_cnt_nxt;
      tour_done <= tour_done_nxt;
      err       <= err_nxt;
      err_code  <= err_code_nxt;
      to_cnt    <= to_cnt_nxt;
    end
  end

  // Next-state: start dominates, then per-state response to pos_vld/timeout
  always_comb begin
    state_nxt     = state;
    visited_nxt   = visited;
    lx_nxt        = lx;
    ly_nxt        = ly;
    mv_cnt_nxt    = mv_cnt;
    tour_done_nxt = tour_done;
    err_nxt       = err;
    err_code_nxt  = err_code;
    to_cnt_nxt    = to_cnt;

    if (start) begin
      visited_nxt   = '0;
      tour_done_nxt = 1'b0;
      err_nxt       = 1'b0;
      err_code_nxt  = EC_NONE;
      to_cnt_nxt    = '0;
      if (!start_on) begin
        state_nxt    = ST_ERR;
        err_nxt      = 1'b1;
        err_code_nxt = EC_OFF;
        mv_cnt_nxt   = '0;
      end else begin
        state_nxt   = ST_TRACK;
        visited_nxt = start_mask;
        lx_nxt      = start_x;
        ly_nxt      = start_y;
        mv_cnt_nxt  = 7'd1;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pos_vld) begin
            state_nxt    = ST_ERR;
            err_nxt      = 1'b1;
            err_code_nxt = EC_IDLE;
          end
        end
        ST_TRACK: begin
          if (pos_vld) begin
            to_cnt_nxt = '0;
            if (!pos_on) begin
              state_nxt    = ST_ERR;
              err_nxt      = 1'b1;
              err_code_nxt = EC_OFF;
            end else if (!knight_ok) begin
              state_nxt    = ST_ERR;
              err_nxt      = 1'b1;
              err_code_nxt = EC_ILLEGAL;
            end else if (revisit) begin
              state_nxt    = ST_ERR;
              err_nxt      = 1'b1;
              err_code_nxt = EC_REVISIT;
            end else begin
              visited_nxt = visited | pos_mask;
              lx_nxt      = pos_x;
              ly_nxt      = pos_y;
              mv_cnt_nxt  = mv_inc;
              if (mv_inc == 7'(NSQ)) begin
                state_nxt     = ST_DONE;
                tour_done_nxt = 1'b1;
              end
            end
          end else if (TIMEOUT_CLKS != 0) begin
            if (to_hit) begin
              state_nxt    = ST_ERR;
              err_nxt      = 1'b1;
              err_code_nxt = EC_TIMEOUT;
            end else begin
              to_cnt_nxt = to_cnt_inc;
            end
          end
        end
        ST_DONE: begin
          if (pos_vld) begin
            state_nxt    = ST_ERR;
            err_nxt      = 1'b1;
            err_code_nxt = EC_AFTER;
          end
        end
        ST_ERR: begin
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule
